// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arb_pkg                                                    |
// | Description : Shared types and limits for the arbitrated input mux.      |
// |               arb_mode_e selects the grant policy of rr_arbiter/arb_mux. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package arb_pkg;

  // Grant policy: fixed priority (lowest index wins) or round-robin.
  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Legal channel-count range for NUM_IN.
  localparam int C_MIN_NUM_IN = 2;
  localparam int C_MAX_NUM_IN = 16;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Purely combinational grant logic. In ARB_RR mode the       |
// |               search starts at ptr and wraps; in ARB_FIXED mode the      |
// |               lowest-index request wins and ptr is ignored.              |
// | Ports       : req       in  NUM_IN  request vector                       |
// |               ptr       in  SEL_W   round-robin search start             |
// |               mode      in  1       grant policy                         |
// |               grant     out NUM_IN  one-hot grant (0 if no request)      |
// |               grant_idx out SEL_W   index of the granted channel         |
// |               any       out 1       at least one request present         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  arb_mode_e         mode,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  logic [NUM_IN-1:0] w_mask;   // channels at or above the search start
  logic [NUM_IN-1:0] w_upper;  // requests in the "before wrap" region
  logic [NUM_IN-1:0] w_pick;   // vector handed to the priority encoder

  // Masking trick: requests at or above ptr take precedence; if none exist
  // the search wraps, which is just a plain lowest-index pick on req.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_mask
    localparam logic [SEL_W:0] c_idx = (SEL_W+1)'(i);
    assign w_mask[i] = (mode == ARB_FIXED) || (c_idx >= {1'b0, ptr});
  end

  assign w_upper = req & w_mask;
  assign w_pick  = (|w_upper) ? w_upper : req;
  assign any     = |req;

  // Lowest set bit of w_pick; iterate downward so the last hit is the lowest.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (w_pick[i]) grant_idx = SEL_W'(i);
    end
  end

  assign grant = any ? ({{(NUM_IN-1){1'b0}}, 1'b1} << grant_idx) : '0;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arb_mux                                                    |
// | Description : N-input valid/ready arbitrated multiplexer with a single   |
// |               registered output stage. One transfer per cycle while      |
// |               out_ready stays high; grant policy set by ARB_MODE.        |
// | Ports       : clk       in  1              rising-edge clock             |
// |               rst       in  1              async active-high reset       |
// |               in_data   in  NUM_IN*DWIDTH  channel i at [i*DWIDTH+:DWIDTH]|
// |               in_valid  in  NUM_IN         per-channel valid             |
// |               in_ready  out NUM_IN         one-hot accept                |
// |               out_data  out DWIDTH         registered selected data      |
// |               out_valid out 1              out_data/out_sel valid        |
// |               out_ready in  1              downstream accept             |
// |               out_sel   out SEL_W          source channel of out_data    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arb_mux
  import arb_pkg::*;
#(
  parameter  int        DWIDTH   = 32,
  parameter  int        NUM_IN   = 4,
  parameter  arb_mode_e ARB_MODE = ARB_RR,
  localparam int        SEL_W    = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_sel
);

  logic [SEL_W-1:0]  r_ptr;
  logic              w_load;
  logic [NUM_IN-1:0] w_grant;
  logic [SEL_W-1:0]  w_grant_idx;
  logic              w_any;
  logic [DWIDTH-1:0] w_chan [NUM_IN];
  logic [SEL_W-1:0]  w_ptr_next;

  // Output register is free when empty or being drained this cycle.
  assign w_load = !out_valid || out_ready;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .mode      (ARB_MODE),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  // rst gates in_ready so no upstream word is consumed while in reset.
  assign in_ready = (w_load && !rst) ? w_grant : '0;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    assign w_chan[i] = in_data[i*DWIDTH +: DWIDTH];
  end

  // Pointer moves to the slot just after the winner, wrapping at NUM_IN-1.
  assign w_ptr_next = (w_grant_idx == SEL_W'(NUM_IN - 1)) ? '0
                                                           : w_grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      if (w_any) begin
        out_valid <= 1'b1;
        out_data  <= w_chan[w_grant_idx];
        out_sel   <= w_grant_idx;
        if (ARB_MODE == ARB_RR) r_ptr <= w_ptr_next;
      end else begin
        // Bubble: data and sel keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule : arb_mux
`default_nettype wire
